// File: rtl/payload_engine_pkg.sv
// Shared constants and helpers for the payload engine matchers.
package payload_engine_pkg;

  // Start-injection modes for the NFA chain
  localparam int ANCHOR_NONE = 0;
  localparam int ANCHOR_SOD  = 1;
  localparam int ANCHOR_LINE = 2;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/payload_nfa_chain_if.sv
// Byte-stream input and match outputs of one NFA rule instance.
interface payload_nfa_chain_if #(
  parameter int NUM_CLASSES = 64,
  parameter int OFF_W       = 16
);
  // en qualifies class_vec as one byte; there is no ready, the matcher accepts every byte.
  logic                   en;
  logic [NUM_CLASSES-1:0] class_vec;
  logic                   match;
  logic                   match_pulse;
  logic [OFF_W-1:0]       match_end;

  modport master (output en, class_vec, input match, match_pulse, match_end);
  modport slave  (input en, class_vec, output match, match_pulse, match_end);
endinterface

// File: rtl/payload_nfa_state.sv
// One NFA state cell: advances on en, cleared asynchronously by rst.
module payload_nfa_state (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic cls_hit,
  input  logic pred_act,
  input  logic loop_en,
  output logic q
);
  logic q_q, q_d;

  always_comb q_d = cls_hit & (pred_act | (loop_en & q_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q_q <= 1'b0;
    else if (en) q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/payload_nfa_chain.sv
// Linear-NFA payload matcher with sticky match, match pulse and match-end offset.
// PAYLOAD_NFA_OFFSET_EN builds the byte counter and match_end; otherwise match_end is 0.
module payload_nfa_chain
  import payload_engine_pkg::*;
#(
  parameter int                            NUM_CLASSES = 64,
  parameter int                            NUM_STATES  = 8,
  parameter int                            CW          = clog2_min1(NUM_CLASSES),
  parameter logic [NUM_STATES*CW-1:0]      CLASS_SEL   = '0,
  parameter logic [NUM_STATES-1:0]         LOOP_MASK   = '0,
  parameter logic [NUM_STATES-1:0]         OPT_MASK    = '0,
  parameter int                            ANCHOR      = ANCHOR_NONE,
  parameter int                            NL_CLASS    = 0,
  parameter int                            OFF_W       = 16
) (
  input  logic              clk,
  input  logic              sod,
  payload_nfa_chain_if.slave bus
);
  localparam logic [CW-1:0] NL_IDX = NL_CLASS[CW-1:0];

  logic [NUM_STATES-1:0] q;
  logic [NUM_STATES:0]   act;   // act[0] is the start term, act[i+1] belongs to state i
  logic                  start;
  logic                  hit;
  logic                  first_q, first_d;
  logic                  nl_prev_q, nl_prev_d;
  logic                  match_q, match_d;
  logic                  match_pulse_q, match_pulse_d;

  always_comb begin
    if (ANCHOR == ANCHOR_SOD)       start = first_q;
    else if (ANCHOR == ANCHOR_LINE) start = first_q | nl_prev_q;
    else                            start = 1'b1;
  end

  always_comb begin
    act    = '0;
    act[0] = start;
    for (int i = 0; i < NUM_STATES; i++)
      act[i+1] = q[i] | (OPT_MASK[i] & act[i]);
  end

  for (genvar g = 0; g < NUM_STATES; g++) begin : g_state
    payload_nfa_state u_state (
      .clk      (clk),
      .rst      (sod),
      .en       (bus.en),
      .cls_hit  (bus.class_vec[CLASS_SEL[g*CW +: CW]]),
      .pred_act (act[g]),
      .loop_en  (LOOP_MASK[g]),
      .q        (q[g])
    );
  end

  assign hit = act[NUM_STATES];

  always_comb begin
    first_d       = bus.en ? 1'b0 : first_q;
    nl_prev_d     = bus.en ? bus.class_vec[NL_IDX] : nl_prev_q;
    match_d       = match_q | hit;
    match_pulse_d = hit & ~match_q;
  end

  always_ff @(posedge clk or posedge sod) begin
    if (sod) begin
      first_q       <= 1'b1;
      nl_prev_q     <= 1'b0;
      match_q       <= 1'b0;
      match_pulse_q <= 1'b0;
    end else begin
      first_q       <= first_d;
      nl_prev_q     <= nl_prev_d;
      match_q       <= match_d;
      match_pulse_q <= match_pulse_d;
    end
  end

  assign bus.match       = match_q;
  assign bus.match_pulse = match_pulse_q;

`ifdef PAYLOAD_NFA_OFFSET_EN
  logic [OFF_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [OFF_W-1:0] match_end_q, match_end_d;

  // match_end takes the pre-increment count, so a byte on the detection edge does not shift it
  always_comb begin
    byte_cnt_d  = (bus.en && (byte_cnt_q != '1)) ? byte_cnt_q + 1'b1 : byte_cnt_q;
    match_end_d = (hit & ~match_q) ? byte_cnt_q : match_end_q;
  end

  always_ff @(posedge clk or posedge sod) begin
    if (sod) begin
      byte_cnt_q  <= '0;
      match_end_q <= '0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      match_end_q <= match_end_d;
    end
  end

  assign bus.match_end = match_end_q;
`else
  assign bus.match_end = '0;
`endif
endmodule

// File: tb/tb_payload_nfa_chain.sv
// Scoreboard bench for payload_nfa_chain: pattern ab*c line-anchored, plus a saturating-offset instance.
module tb_payload_nfa_chain;
  import payload_engine_pkg::*;

  localparam int CA = 0, CB = 1, CC = 2, CNL = 3, CX = 4, CY = 5, CZ = 6;
`ifdef PAYLOAD_NFA_OFFSET_EN
  localparam bit OFF_EN = 1'b1;
`else
  localparam bit OFF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic sod_a, sod_b;
  always #5 clk = ~clk;

  payload_nfa_chain_if #(.NUM_CLASSES(8), .OFF_W(8)) bus_a ();
  payload_nfa_chain_if #(.NUM_CLASSES(8), .OFF_W(3)) bus_b ();

  payload_nfa_chain #(
    .NUM_CLASSES(8), .NUM_STATES(3), .CLASS_SEL(9'({3'd2, 3'd1, 3'd0})),
    .LOOP_MASK(3'b010), .OPT_MASK(3'b010), .ANCHOR(ANCHOR_LINE),
    .NL_CLASS(3), .OFF_W(8)
  ) dut_a (.clk(clk), .sod(sod_a), .bus(bus_a));

  payload_nfa_chain #(
    .NUM_CLASSES(8), .NUM_STATES(3), .CLASS_SEL(9'({3'd2, 3'd1, 3'd0})),
    .LOOP_MASK(3'b010), .OPT_MASK(3'b010), .ANCHOR(ANCHOR_NONE),
    .NL_CLASS(3), .OFF_W(3)
  ) dut_b (.clk(clk), .sod(sod_b), .bus(bus_b));

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_a_q[$];
  logic [2:0] exp_b_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitors: every match_pulse pops one expected match_end
  logic prev_pulse_a = 1'b0, prev_pulse_b = 1'b0;
  always @(negedge clk) begin
    logic [7:0] e;
    if (bus_a.match_pulse === 1'b1) begin
      check("a_pulse_match", bus_a.match, 1);
      check("a_pulse_width", prev_pulse_a, 0);
      if (exp_a_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_pulse actual=1 required=0");
      end else begin
        e = exp_a_q.pop_front();
        check("a_match_end", bus_a.match_end, OFF_EN ? e : 8'd0);
      end
    end
    prev_pulse_a = bus_a.match_pulse;
  end

  always @(negedge clk) begin
    logic [2:0] e;
    if (bus_b.match_pulse === 1'b1) begin
      check("b_pulse_match", bus_b.match, 1);
      check("b_pulse_width", prev_pulse_b, 0);
      if (exp_b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_pulse actual=1 required=0");
      end else begin
        e = exp_b_q.pop_front();
        check("b_match_end", bus_b.match_end, OFF_EN ? e : 3'd0);
      end
    end
    prev_pulse_b = bus_b.match_pulse;
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input int cls);
    if (sel) begin bus_b.en = 1'b1; bus_b.class_vec = 8'(1 << cls); end
    else     begin bus_a.en = 1'b1; bus_a.class_vec = 8'(1 << cls); end
    idle();
    bus_a.en = 1'b0; bus_a.class_vec = '0;
    bus_b.en = 1'b0; bus_b.class_vec = '0;
  endtask

  task automatic do_sod(input bit sel);
    if (sel) sod_b = 1'b1; else sod_a = 1'b1;
    #2;
    sod_a = 1'b0; sod_b = 1'b0;
    if (sel) begin
      check("b_rst_match", bus_b.match, 0);
      check("b_rst_end", bus_b.match_end, 0);
    end else begin
      check("a_rst_match", bus_a.match, 0);
      check("a_rst_pulse", bus_a.match_pulse, 0);
      check("a_rst_end", bus_a.match_end, 0);
    end
  endtask

  task automatic settle(input bit sel, input bit exp_match);
    repeat (3) idle();
    if (sel) begin
      check("b_match_level", bus_b.match, exp_match);
      check("b_pending_pulses", exp_b_q.size(), 0);
    end else begin
      check("a_match_level", bus_a.match, exp_match);
      check("a_pulse_low", bus_a.match_pulse, 0);
      check("a_pending_pulses", exp_a_q.size(), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sod_a = 1'b1; sod_b = 1'b1;
    bus_a.en = 1'b0; bus_a.class_vec = '0;
    bus_b.en = 1'b0; bus_b.class_vec = '0;
    repeat (2) @(posedge clk);
    #1;
    check("a_init_match", bus_a.match, 0);
    check("a_init_pulse", bus_a.match_pulse, 0);
    check("a_init_end", bus_a.match_end, 0);
    sod_a = 1'b0; sod_b = 1'b0;

    // "ac" right after sod
    send(0, CA); exp_a_q.push_back(8'd2); send(0, CC);
    settle(0, 1);

    // "abbbc" with idles, then trailing bytes including one on the detection edge
    do_sod(0);
    send(0, CA); send(0, CB); idle(); idle(); send(0, CB); send(0, CB);
    exp_a_q.push_back(8'd5); send(0, CC);
    send(0, CX); send(0, CY); send(0, CZ);
    settle(0, 1);
    check("a_end_held", bus_a.match_end, OFF_EN ? 8'd5 : 8'd0);

    // "xac" never starts: anchored to data start
    do_sod(0);
    send(0, CX); send(0, CA); send(0, CC);
    settle(0, 0);

    // "x" NL "ac": newline re-arms the start
    do_sod(0);
    send(0, CX); send(0, CNL); send(0, CA);
    exp_a_q.push_back(8'd4); send(0, CC);
    settle(0, 1);

    // sod mid-pattern discards the partial "ab"
    do_sod(0);
    send(0, CA); send(0, CB);
    do_sod(0);
    send(0, CC);
    settle(0, 0);
    do_sod(0);
    send(0, CA); exp_a_q.push_back(8'd2); send(0, CC);
    settle(0, 1);

    // "abc" back-to-back with en held high through detection
    do_sod(0);
    send(0, CA); send(0, CB); exp_a_q.push_back(8'd3); send(0, CC);
    send(0, CX);
    settle(0, 1);

    // unanchored, 3-bit offset saturates at 7
    do_sod(1);
    for (int i = 0; i < 9; i++) send(1, CX);
    send(1, CA); exp_b_q.push_back(3'd7); send(1, CC);
    settle(1, 1);
    check("b_end_sat", bus_b.match_end, OFF_EN ? 3'd7 : 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
